alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Sequential 32x32 -> 64-bit unsigned multiplier built on one instance of the team's 32-bit ripple ALU, using one shift-add iteration per clock. It sits beside the ALU in the execute stage and lets the core issue multiply operations without adding a dedicated array multiplier. A start/busy/done handshake makes it a 33-cycle functional unit.

## Interface
Parameters:
- WIDTH, 32, operand width; only 32 is supported because it must match the ALU width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- multiplicand  input  32  operand A; captured on an accepted start
- multiplier  input  32  operand B; captured on an accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when product is valid
- product  output  64  result; held until the next accepted start
- product_zero  output  1  product == 0; valid with done and held afterwards

## Operation
- Internal registers:
  - M[31:0] holds the multiplicand.
  - {C, P_hi[31:0], P_lo[31:0]} is a 65-bit accumulator.
  - cnt[4:0] counts iterations.
- ALU drive:
  - ALU_control is constant ADD (4'b0010), with src1 = P_hi, src2 = M, and the ALU's rst_n tied to the block's rst_n.
  - Use only the ALU result. Do not use the ALU's cout.
  - Derive carry locally: c = (P_hi[31] & M[31]) | ((P_hi[31] | M[31]) & ~sum[31]).
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE, start=1:
  - M <= multiplicand, P_hi <= 0, P_lo <= multiplier, cnt <= 0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each cycle:
  - If P_lo[0]=1: {P_hi, P_lo} <= {c, sum, P_lo[31:1]}.
  - Otherwise: {P_hi, P_lo} <= {1'b0, P_hi, P_lo[31:1]}.
  - cnt <= cnt + 1.
  - When cnt == 31, go to DONE after that shift.
- product = {P_hi, P_lo}, driven continuously from the registers.
  - It is meaningful in DONE and after.
  - During RUN it shows partial state, and consumers must ignore it.
- start while busy=1 is ignored. No queueing; the operands are not re-captured.
- The result is exact for all unsigned inputs, so there is no overflow output.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, product_zero=1, cnt=0, M=0.
- Reset asserted mid-RUN aborts the operation immediately and forces the reset values. No done pulse follows.
- Latency:
  - start is high in cycle 0 (accepted at the edge ending cycle 0).
  - busy is high in cycles 1..32.
  - done is high in cycle 33 only, with product and product_zero valid in that cycle.
- Back-to-back: start=1 in the DONE cycle is accepted. busy rises the next cycle and done falls. Throughput is one multiply per 33 cycles.
- done and busy are registered state decodes with no combinational path from start.
- The ALU path is combinational within one cycle: P_hi/M registers -> 32-bit ripple -> accumulator register. This is the critical path.

## Structure
- Shared package alu_pkg holds:
  - ALU op constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - The mul_state_t enum {IDLE, RUN, DONE}.
  - MUL_ITER=32.
- One sub-module: the existing alu, instantiated once and unmodified.
- Carry derivation, the accumulator and the FSM live in alu_mul_seq.

## Test plan
- Basic: 3 x 5 -> done in cycle 33, product=64'd15, product_zero=0; busy high for exactly 32 cycles.
- Max carry: 0xFFFFFFFF x 0xFFFFFFFF -> product=64'hFFFFFFFE_00000001. This checks the local carry path.
- Zero: 0 x 0x12345678 -> product=0, product_zero=1. Also 0x80000000 x 2 -> product=64'h1_00000000.
- Ignored start: start with 7 x 9, then pulse start with 1 x 1 in cycle 10 -> done at cycle 33 with product=63. No second done follows.
- Reset mid-op: start 0xDEADBEEF x 0x10, deassert rst_n in cycle 15 -> busy=0, product=0, state IDLE. The next 2 x 2 gives product=4 after 33 cycles.
- Back-to-back: a second start (6 x 7) held high in the DONE cycle of 4 x 4 -> done carries 16, then busy is high the next cycle, and 42 arrives 33 cycles after the second acceptance.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, multiplier FSM states and iteration count
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ripple-carry ALU (AND/OR/ADD/SUB/SLT/NOR)
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             rst_n,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    assign w_sub = (ALU_control == ALU_SUB) || (ALU_control == ALU_SLT);
    assign w_b   = w_sub ? ~src2 : src2;

    always_comb begin
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = w_sub;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]  = src1[i] ^ w_b[i] ^ w_c[i];
            w_c[i+1]  = (src1[i] & w_b[i]) | (w_c[i] & (src1[i] ^ w_b[i]));
        end
    end

    // Signed overflow corrects the sign bit for SLT.
    assign w_ovf = (src1[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);

    always_comb begin
        result = '0;
        if (rst_n) begin
            case (ALU_control)
                ALU_AND: result = src1 & src2;
                ALU_OR:  result = src1 | src2;
                ALU_ADD: result = w_sum;
                ALU_SUB: result = w_sum;
                ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
                ALU_NOR: result = ~(src1 | src2);
                default: result = '0;
            endcase
        end
    end

    assign zero = (result == '0);
    assign cout = rst_n & w_c[WIDTH];

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential 32x32->64 unsigned shift-add multiplier on one ALU
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               product_zero
);

    localparam logic [4:0] LAST_CNT = 5'(MUL_ITER - 1);

    mul_state_t       r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic [4:0]       r_cnt;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_alu_zero;
    logic             w_alu_cout;
    logic             w_unused;

    alu #(.WIDTH(WIDTH)) u_alu (
        .rst_n       (rst_n),
        .ALU_control (ALU_ADD),
        .src1        (r_p_hi),
        .src2        (r_m),
        .result      (w_sum),
        .zero        (w_alu_zero),
        .cout        (w_alu_cout)
    );

    assign w_unused = w_alu_zero ^ w_alu_cout;

    // Carry-out recovered from operand and sum MSBs so the ALU's cout is not needed.
    assign w_carry = (r_p_hi[WIDTH-1] & r_m[WIDTH-1])
                   | ((r_p_hi[WIDTH-1] | r_m[WIDTH-1]) & ~w_sum[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_p_hi  <= '0;
                        r_p_lo  <= multiplier;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_p_lo[0]) begin
                        {r_p_hi, r_p_lo} <= {w_carry, w_sum, r_p_lo[WIDTH-1:1]};
                    end else begin
                        {r_p_hi, r_p_lo} <= {1'b0, r_p_hi, r_p_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = (r_state == RUN);
    assign done         = (r_state == DONE);
    assign product      = {r_p_hi, r_p_lo};
    assign product_zero = (product == '0);

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed self-checking bench for alu_mul_seq
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        product_zero;

    int errors = 0;
    int checks = 0;
    int n;
    int bc;
    int extra_done;

    alu_mul_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .product_zero (product_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives start during cycle 0; returns at the negedge of cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int cyc, output int busy_cycles);
        cyc = n0;
        busy_cycles = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_pzero", 64'(product_zero), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Basic 3 x 5
        launch(32'd3, 32'd5);
        wait_done(1, n, bc);
        chk("basic_done_cycle", 64'(n), 64'd33);
        chk("basic_busy_cycles", 64'(bc), 64'd32);
        chk("basic_product", product, 64'd15);
        chk("basic_pzero", 64'(product_zero), 64'd0);
        @(negedge clk);
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_hold", product, 64'd15);

        // Max carry
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, n, bc);
        chk("max_done_cycle", 64'(n), 64'd33);
        chk("max_product", product, 64'hFFFF_FFFE_0000_0001);

        // Zero multiplicand
        launch(32'd0, 32'h1234_5678);
        wait_done(1, n, bc);
        chk("zero_done_cycle", 64'(n), 64'd33);
        chk("zero_product", product, 64'd0);
        chk("zero_pzero", 64'(product_zero), 64'd1);

        launch(32'h8000_0000, 32'd2);
        wait_done(1, n, bc);
        chk("msb_product", product, 64'h1_0000_0000);
        chk("msb_pzero", 64'(product_zero), 64'd0);

        // Start during RUN is ignored
        launch(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        wait_done(11, n, bc);
        chk("ign_done_cycle", 64'(n), 64'd33);
        chk("ign_product", product, 64'd63);
        count_done(40, extra_done);
        chk("ign_no_second_done", 64'(extra_done), 64'd0);

        // Asynchronous reset mid-operation
        launch(32'hDEAD_BEEF, 32'h10);
        repeat (14) @(negedge clk);
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        chk("rstmid_product", product, 64'd0);
        chk("rstmid_pzero", 64'(product_zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, extra_done);
        chk("rstmid_no_done", 64'(extra_done), 64'd0);
        chk("rstmid_idle", 64'(busy), 64'd0);
        launch(32'd2, 32'd2);
        wait_done(1, n, bc);
        chk("rstmid_next_cycle", 64'(n), 64'd33);
        chk("rstmid_next_product", product, 64'd4);

        // Back-to-back: start held in DONE cycle
        launch(32'd4, 32'd4);
        wait_done(1, n, bc);
        chk("b2b_first_cycle", 64'(n), 64'd33);
        chk("b2b_first_product", product, 64'd16);
        start        = 1'b1;
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_rise", 64'(busy), 64'd1);
        chk("b2b_done_fall", 64'(done), 64'd0);
        wait_done(1, n, bc);
        chk("b2b_second_cycle", 64'(n), 64'd33);
        chk("b2b_second_busy", 64'(bc), 64'd32);
        chk("b2b_second_product", product, 64'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
